// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command driver: op codes, FSM encoding,
// the packed command record and the calculator's divide-by-zero result.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_DIV = 4'h3;
    localparam logic [3:0] OP_MOD = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_SLL = 4'h8;
    localparam logic [3:0] OP_SRL = 4'h9;
    localparam logic [3:0] OP_SRA = 4'hA;
    localparam logic [3:0] OP_MAX = 4'hA;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_ISSUE_ENC = 2'd1;
    localparam logic [1:0] ST_WAIT_ENC  = 2'd2;
    localparam logic [1:0] ST_RESP_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_ISSUE = ST_ISSUE_ENC,
        ST_WAIT  = ST_WAIT_ENC,
        ST_RESP  = ST_RESP_ENC
    } state_e;

    localparam logic [31:0] DIV0_RESULT = 32'h0000_FFFF;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
    } cmd_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= OP_MAX;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; an extra pointer bit distinguishes full from empty.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push_i,
    input  logic pop_i,
    input  cmd_t wdata_i,
    output cmd_t rdata_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    cmd_t mem_q [DEPTH];
    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    logic do_push, do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign rdata_o = mem_q[rd_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign wr_d    = do_push ? wr_q + PTR_ONE : wr_q;
    assign rd_d    = do_pop  ? rd_q + PTR_ONE : rd_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// Initiator side of the calculator start/done handshake: buffers commands,
// issues them one at a time and returns result, tag and error on a response stream.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [15:0]      cmd_a,
    input  logic [15:0]      cmd_b,
    input  logic [3:0]       cmd_op,
    output logic             cal_start,
    output logic [15:0]      cal_a,
    output logic [15:0]      cal_b,
    output logic [3:0]       cal_op,
    input  logic [31:0]      cal_result,
    input  logic             cal_done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_e state_q, state_d;

    logic fifo_push, fifo_pop, fifo_full, fifo_empty;
    cmd_t fifo_wdata, fifo_rdata;

    logic [15:0]      cal_a_q, cal_a_d;
    logic [15:0]      cal_b_q, cal_b_d;
    logic [3:0]       cal_op_q, cal_op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [TAG_W-1:0] tag_cnt_q, tag_cnt_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic [31:0]      result_q, result_d;
    logic             err_q, err_d;

    assign fifo_wdata = {cmd_a, cmd_b, cmd_op};
    assign fifo_push  = cmd_valid && !fifo_full;
    assign cmd_ready  = !fifo_full;

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (!fifo_empty) state_d = op_is_legal(fifo_rdata.op) ? ST_ISSUE : ST_RESP;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (cal_done || tmo_q == TMO_LAST) state_d = ST_RESP;
            ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs plus datapath next-state; done wins over a simultaneous timeout.
    always_comb begin
        cal_start = (state_q == ST_ISSUE);
        rsp_valid = (state_q == ST_RESP);
        busy      = (state_q != ST_IDLE) || !fifo_empty;
        fifo_pop  = 1'b0;
        cal_a_d   = cal_a_q;
        cal_b_d   = cal_b_q;
        cal_op_d  = cal_op_q;
        tag_d     = tag_q;
        tag_cnt_d = tag_cnt_q;
        tmo_d     = tmo_q;
        result_d  = result_q;
        err_d     = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    cal_a_d   = fifo_rdata.a;
                    cal_b_d   = fifo_rdata.b;
                    cal_op_d  = fifo_rdata.op;
                    tag_d     = tag_cnt_q;
                    tag_cnt_d = tag_cnt_q + 1'b1;
                    if (!op_is_legal(fifo_rdata.op)) begin
                        result_d = '0;
                        err_d    = 1'b1;
                    end
                end
            end
            ST_ISSUE: tmo_d = '0;
            ST_WAIT: begin
                if (cal_done) begin
                    result_d = cal_result;
                    err_d    = 1'b0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_q == TMO_LAST) begin
                        result_d = '0;
                        err_d    = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cal_a_q   <= '0;
            cal_b_q   <= '0;
            cal_op_q  <= '0;
            tag_q     <= '0;
            tag_cnt_q <= '0;
            tmo_q     <= '0;
            result_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            cal_a_q   <= cal_a_d;
            cal_b_q   <= cal_b_d;
            cal_op_q  <= cal_op_d;
            tag_q     <= tag_d;
            tag_cnt_q <= tag_cnt_d;
            tmo_q     <= tmo_d;
            result_q  <= result_d;
            err_q     <= err_d;
        end
    end

    assign cal_a      = cal_a_q;
    assign cal_b      = cal_b_q;
    assign cal_op     = cal_op_q;
    assign rsp_result = result_q;
    assign rsp_tag    = tag_q;
    assign rsp_err    = err_q;

endmodule
